exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, exception handler entry address.
REQ-002 Parameter IRQ_ESTATUS, default 4'b0001, ESR code for an external interrupt.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 pc_i  input  64  PC of the instruction currently in decode.
REQ-006 not_an_instr_i  input  1  decoder flag for an undefined opcode (synchronous exception).
REQ-007 estatus_i  input  4  decoder exception code, valid with not_an_instr_i.
REQ-008 eret_i  input  1  decoder flag for ERET.
REQ-009 ext_irq_i  input  1  level-sensitive external interrupt request.
REQ-010 flush_o  output  1  suppresses RegWrite/MemWrite/MemRead of the current instruction.
REQ-011 redirect_o  output  1  PC mux select; takes redirect_pc_o next cycle.
REQ-012 redirect_pc_o  output  64  redirect target.
REQ-013 elr_o  output  64  exception link register, readable via MRS path.
REQ-014 esr_o  output  4  exception syndrome register, readable via MRS path.
REQ-015 exc_active_o  output  1  high while in ENTER, HANDLER or RETURN.
REQ-016 irq_ack_o  output  1  one-cycle pulse when an interrupt is taken.
REQ-017 fatal_o  output  1  sticky double-fault indicator.

Function
REQ-018 FSM states: IDLE, ENTER, HANDLER, RETURN, HALT.
REQ-019 irq_pending is set on any cycle with ext_irq_i=1 and is cleared only when the interrupt is taken.
REQ-020 IDLE, not_an_instr_i=1: flush_o=1 combinationally that cycle; ELR<=pc_i; ESR<=estatus_i; next state ENTER.
REQ-021 IDLE, not_an_instr_i=0, irq_pending=1 or ext_irq_i=1: flush_o=1; ELR<=pc_i; ESR<=IRQ_ESTATUS; irq_ack_o=1; clear pending; next state ENTER.
REQ-022 Simultaneous sync exception and IRQ: sync wins; IRQ stays pending; irq_ack_o=0.
REQ-023 IDLE, eret_i=1 with no exception: ignored; no redirect; no state change.
REQ-024 ENTER: redirect_o=1, redirect_pc_o=VECTOR_ADDR for exactly one cycle; next state HANDLER.
REQ-025 HANDLER: IRQs are latched into pending but not taken; ELR/ESR hold.
REQ-026 HANDLER, eret_i=1: next state RETURN; flush_o=0.
REQ-027 HANDLER, not_an_instr_i=1: double fault; flush_o=1; fatal_o<=1; ELR/ESR hold; next state HALT (takes priority over eret_i).
REQ-028 RETURN: redirect_o=1, redirect_pc_o=ELR for one cycle; next state IDLE.
REQ-029 A pending IRQ is taken no earlier than the first IDLE cycle after RETURN.
REQ-030 HALT: redirect_o=0, flush_o=1 every cycle, fatal_o=1; exit only by reset.
REQ-031 redirect_pc_o=0 whenever redirect_o=0.
REQ-032 Latency: an exception detected in cycle N gives flush in N, redirect in N+1, and exc_active_o from N+1.

Reset
REQ-033 reset=1 at a clock edge forces: state=IDLE, ELR=0, ESR=0, irq_pending=0, fatal_o=0.
REQ-034 While reset=1, all outputs are 0, including the combinational flush_o and irq_ack_o.
REQ-035 Reset in any state, including mid-ENTER or mid-RETURN, aborts the redirect with no residual pulse.

Structure
REQ-036 A shared package holds the FSM state enum, the ESR code constants (0010 undefined instruction, 0001 IRQ) and VECTOR_ADDR.
REQ-037 The block is a single module with no sub-module; the ELR/ESR register pair is coded inline.

Verification
REQ-038 IDLE, pc_i=0x40, not_an_instr_i=1, estatus_i=0010 -> flush_o=1 that cycle; next cycle redirect_o=1 to 0xD8; esr_o=0010, elr_o=0x40.
REQ-039 ext_irq_i pulsed one cycle while in HANDLER, then eret_i -> RETURN redirects to ELR; next IDLE cycle gives irq_ack_o=1 and esr_o=0001.
REQ-040 Same cycle: not_an_instr_i=1 and ext_irq_i=1 at pc_i=0x80 -> esr_o=0010; the IRQ is taken after the ERET round trip.
REQ-041 not_an_instr_i=1 while in HANDLER -> fatal_o=1; state HALT; flush_o stays high until reset.
REQ-042 reset asserted during the ENTER cycle -> next cycle redirect_o=0, exc_active_o=0, elr_o=0.
REQ-043 eret_i=1 while in IDLE -> no redirect_o, no state change.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exc_ctrl_pkg
//   Shared definitions for the exception controller: FSM state encoding,
//   exception syndrome codes and the default handler vector address.
// ----------------------------------------------------------------------------
package exc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTER   = 3'd1,
      ST_HANDLER = 3'd2,
      ST_RETURN  = 3'd3,
      ST_HALT    = 3'd4
   } exc_state_e;

   // ESR syndrome codes
   localparam logic [3:0]  ESR_UNDEF = 4'b0010;  // undefined instruction
   localparam logic [3:0]  ESR_IRQ   = 4'b0001;  // external interrupt

   // Default exception handler entry point
   localparam logic [63:0] VECTOR_ADDR_DEF = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl
//   Exception / interrupt controller for the decode stage. Takes synchronous
//   undefined-instruction exceptions and level-sensitive external interrupts,
//   redirects fetch to the handler vector, and returns to ELR on ERET.
//   A synchronous exception inside the handler is a double fault and parks
//   the block in HALT until reset.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   pc_i           in   64  PC of the instruction in decode
//   not_an_instr_i in   undefined opcode flag (synchronous exception)
//   estatus_i      in   4   exception code, valid with not_an_instr_i
//   eret_i         in   ERET decoded
//   ext_irq_i      in   level-sensitive interrupt request
//   flush_o        out  kill side effects of the current instruction
//   redirect_o     out  PC mux select for next fetch
//   redirect_pc_o  out  64  redirect target (0 when redirect_o=0)
//   elr_o          out  64  exception link register
//   esr_o          out  4   exception syndrome register
//   exc_active_o   out  high in ENTER, HANDLER, RETURN
//   irq_ack_o      out  one-cycle pulse when an interrupt is taken
//   fatal_o        out  sticky double-fault flag
// ----------------------------------------------------------------------------
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [63:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
   parameter logic [3:0]  IRQ_ESTATUS = ESR_IRQ
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc_i,
   input  logic        not_an_instr_i,
   input  logic [3:0]  estatus_i,
   input  logic        eret_i,
   input  logic        ext_irq_i,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [63:0] redirect_pc_o,
   output logic [63:0] elr_o,
   output logic [3:0]  esr_o,
   output logic        exc_active_o,
   output logic        irq_ack_o,
   output logic        fatal_o
);

   exc_state_e  state_q, state_d;
   logic [63:0] elr_q, elr_d;
   logic [3:0]  esr_q, esr_d;
   logic        irq_pend_q, irq_pend_d;
   logic        fatal_q, fatal_d;

   logic        take_sync;
   logic        take_irq;
   logic        dbl_fault;

   // Sync exception beats the interrupt; the interrupt stays pending.
   assign take_sync = (state_q == ST_IDLE) && not_an_instr_i;
   assign take_irq  = (state_q == ST_IDLE) && !not_an_instr_i &&
                      (irq_pend_q || ext_irq_i);
   assign dbl_fault = (state_q == ST_HANDLER) && not_an_instr_i;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            // ERET with nothing to return from is ignored
            if (take_sync || take_irq) state_d = ST_ENTER;
         end
         ST_ENTER:   state_d = ST_HANDLER;
         ST_HANDLER: begin
            if (not_an_instr_i) state_d = ST_HALT;
            else if (eret_i)    state_d = ST_RETURN;
         end
         ST_RETURN:  state_d = ST_IDLE;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // ELR / ESR / pending IRQ / fatal flag
   // ------------------------------------------------------------------
   always_comb begin
      elr_d = elr_q;
      esr_d = esr_q;
      if (take_sync) begin
         elr_d = pc_i;
         esr_d = estatus_i;
      end else if (take_irq) begin
         elr_d = pc_i;
         esr_d = IRQ_ESTATUS;
      end
      // Latch requests in every state; only taking the IRQ clears it.
      irq_pend_d = take_irq ? 1'b0 : (irq_pend_q || ext_irq_i);
      fatal_d    = fatal_q || dbl_fault;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         elr_q      <= '0;
         esr_q      <= '0;
         irq_pend_q <= 1'b0;
         fatal_q    <= 1'b0;
      end else begin
         elr_q      <= elr_d;
         esr_q      <= esr_d;
         irq_pend_q <= irq_pend_d;
         fatal_q    <= fatal_d;
      end
   end

   // ------------------------------------------------------------------
   // Output logic. Everything is forced low while reset is high so an
   // in-flight redirect is dropped on the reset cycle itself.
   // ------------------------------------------------------------------
   always_comb begin
      flush_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      elr_o         = '0;
      esr_o         = '0;
      exc_active_o  = 1'b0;
      irq_ack_o     = 1'b0;
      fatal_o       = 1'b0;
      if (!reset) begin
         elr_o   = elr_q;
         esr_o   = esr_q;
         fatal_o = fatal_q;
         unique case (state_q)
            ST_IDLE: begin
               flush_o   = take_sync || take_irq;
               irq_ack_o = take_irq;
            end
            ST_ENTER: begin
               redirect_o    = 1'b1;
               redirect_pc_o = VECTOR_ADDR;
               exc_active_o  = 1'b1;
            end
            ST_HANDLER: begin
               flush_o      = dbl_fault;
               exc_active_o = 1'b1;
            end
            ST_RETURN: begin
               redirect_o    = 1'b1;
               redirect_pc_o = elr_q;
               exc_active_o  = 1'b1;
            end
            ST_HALT: begin
               flush_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

   localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] pc_i = '0;
   logic        not_an_instr_i = 1'b0;
   logic [3:0]  estatus_i = '0;
   logic        eret_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic        flush_o, redirect_o, exc_active_o, irq_ack_o, fatal_o;
   logic [63:0] redirect_pc_o, elr_o;
   logic [3:0]  esr_o;

   exc_ctrl dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .not_an_instr_i(not_an_instr_i),
      .estatus_i(estatus_i), .eret_i(eret_i), .ext_irq_i(ext_irq_i),
      .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
      .elr_o(elr_o), .esr_o(esr_o), .exc_active_o(exc_active_o),
      .irq_ack_o(irq_ack_o), .fatal_o(fatal_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        flush;
      logic        redir;
      logic [63:0] rpc;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic        act;
      logic        ack;
      logic        fatal;
   } obs_t;

   obs_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: what the controller is doing, in plain terms.
   bit          m_halted, m_in_handler, m_redir_due, m_redir_to_handler;
   bit          m_pend, m_fatal;
   logic [63:0] m_tgt, m_elr;
   logic [3:0]  m_esr;

   task automatic model_clear();
      m_halted = 0; m_in_handler = 0; m_redir_due = 0; m_redir_to_handler = 0;
      m_pend = 0; m_fatal = 0; m_tgt = '0; m_elr = '0; m_esr = '0;
   endtask

   // Start an exception: record link/syndrome, schedule jump to vector.
   task automatic model_enter(input logic [63:0] pc, input logic [3:0] code);
      m_elr = pc; m_esr = code;
      m_redir_due = 1; m_redir_to_handler = 1; m_tgt = VEC;
   endtask

   task automatic step(input bit r, input logic [63:0] pc, input bit nai,
                       input logic [3:0] es, input bit er, input bit irq);
      obs_t e;
      bit   taken;
      @(posedge clk); #1;
      reset = r; pc_i = pc; not_an_instr_i = nai; estatus_i = es;
      eret_i = er; ext_irq_i = irq;
      e = '0;
      if (r) begin
         model_clear();
      end else begin
         taken = 0;
         e.elr = m_elr; e.esr = m_esr; e.fatal = m_fatal;
         if (m_halted) begin
            e.flush = 1;
         end else if (m_redir_due) begin
            e.redir = 1; e.rpc = m_tgt; e.act = 1;
            m_redir_due = 0; m_in_handler = m_redir_to_handler;
         end else if (m_in_handler) begin
            e.act = 1;
            if (nai) begin
               e.flush = 1; m_fatal = 1; m_halted = 1; m_in_handler = 0;
            end else if (er) begin
               m_in_handler = 0; m_redir_due = 1; m_redir_to_handler = 0;
               m_tgt = m_elr;
            end
         end else begin
            if (nai) begin
               e.flush = 1; model_enter(pc, es);
            end else if (m_pend || irq) begin
               e.flush = 1; e.ack = 1; taken = 1; model_enter(pc, 4'b0001);
            end
         end
         m_pend = taken ? 1'b0 : (m_pend || irq);
      end
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 64'h1000 + 64'(i * 4), 0, 4'h0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output bundle.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a.flush = flush_o; a.redir = redirect_o; a.rpc = redirect_pc_o;
            a.elr = elr_o; a.esr = esr_o; a.act = exc_active_o;
            a.ack = irq_ack_o; a.fatal = fatal_o;
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL vec%0d outputs: got flush=%0b redir=%0b rpc=%h elr=%h esr=%h act=%0b ack=%0b fatal=%0b ; want flush=%0b redir=%0b rpc=%h elr=%h esr=%h act=%0b ack=%0b fatal=%0b",
                        n_vec, a.flush, a.redir, a.rpc, a.elr, a.esr, a.act, a.ack, a.fatal,
                        e.flush, e.redir, e.rpc, e.elr, e.esr, e.act, e.ack, e.fatal);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      model_clear();
      // reset state
      step(1, 64'h0, 0, 4'h0, 0, 0);
      step(1, 64'h0, 1, 4'h2, 1, 1);
      idle(2);

      // undefined instruction at 0x40, handler, return
      step(0, 64'h40, 1, 4'b0010, 0, 0);
      idle(3);
      step(0, 64'h2000, 0, 4'h0, 1, 0);
      idle(3);

      // IRQ pulse inside handler is held until after RETURN
      step(0, 64'h44, 1, 4'b0010, 0, 0);
      step(0, 64'h0, 0, 4'h0, 0, 0);
      step(0, 64'h0, 0, 4'h0, 0, 1);
      idle(2);
      step(0, 64'h0, 0, 4'h0, 1, 0);
      idle(4);
      step(0, 64'h0, 0, 4'h0, 1, 0);
      idle(3);

      // simultaneous sync exception and IRQ at 0x80
      step(0, 64'h80, 1, 4'b0010, 0, 1);
      idle(2);
      step(0, 64'h0, 0, 4'h0, 1, 0);
      idle(4);
      step(0, 64'h0, 0, 4'h0, 1, 0);
      idle(3);

      // eret in IDLE ignored
      step(0, 64'h90, 0, 4'h0, 1, 0);
      idle(2);

      // double fault -> HALT until reset
      step(0, 64'h100, 1, 4'b0010, 0, 0);
      idle(2);
      step(0, 64'h104, 1, 4'b0111, 1, 0);
      step(0, 64'h108, 1, 4'h2, 1, 1);
      idle(4);
      step(1, 64'h0, 0, 4'h0, 0, 0);
      idle(2);

      // reset during ENTER and during RETURN
      step(0, 64'h200, 1, 4'b0010, 0, 0);
      step(1, 64'h0, 0, 4'h0, 0, 0);
      idle(3);
      step(0, 64'h300, 1, 4'b0010, 0, 0);
      idle(2);
      step(0, 64'h0, 0, 4'h0, 1, 0);
      step(1, 64'h0, 0, 4'h0, 0, 0);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(99) < 2),
              {$urandom, $urandom},
              ($urandom_range(99) < 8),
              4'($urandom),
              ($urandom_range(99) < 20),
              ($urandom_range(99) < 6));
      end
      idle(2);

      wait_cyc = 0;
      while (sbq.size() > 0 && wait_cyc < 10) begin
         @(negedge clk); wait_cyc++;
      end
      @(negedge clk);
      if (sbq.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d entries left, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
